tdc_phase_sweep: RTL and testbench

TDC_PHASE_SWEEP -- requirements
Module: tdc_phase_sweep

---
 rtl/tdc_pkg.sv | 22 ++
 rtl/tdc_popcount.sv | 30 +++
 rtl/tdc_phase_sweep.sv | 164 ++++++++++++++++
 tb/tb_tdc_phase_sweep.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC phase-sweep controller: FSM encoding and fixed timing constants.
package tdc_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StLockWait,
    StPhReq,
    StPhAck,
    StPhSettle,
    StFire,
    StCapture,
    StAccum,
    StClear,
    StWrite,
    StFinish,
    StError
  } tdc_state_e;

  // Cycles the PLL output is left to settle after a phase step before the chain is fired.
  localparam int unsigned SettleCycles = 2;

endpackage

// File: rtl/tdc_popcount.sv
// Ones-count of the carry-chain thermometer code; counting ones rather than finding the edge
// makes the result tolerant of bubbles. Result is registered (one cycle of latency).
module tdc_popcount #(
  parameter int unsigned N_TAPS = 256,
  parameter int unsigned CODE_W = $clog2(N_TAPS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_TAPS-1:0] sout,
  output logic [CODE_W-1:0] count
);

  logic [CODE_W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < int'(N_TAPS); i++) begin
      sum = sum + CODE_W'(sout[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= sum;
    end
  end

endmodule

// File: rtl/tdc_phase_sweep.sv
// Sweeps the PLL sampling phase across N_STEPS steps, firing the carry chain N_REPEAT times per
// step and writing the accumulated ones-count for each step to memory.
module tdc_phase_sweep
  import tdc_pkg::*;
#(
  parameter int unsigned N_TAPS     = 256,
  parameter int unsigned N_STEPS    = 512,
  parameter int unsigned N_REPEAT   = 4,
  parameter int unsigned PH_TIMEOUT = 1023,
  localparam int unsigned CODE_W    = $clog2(N_TAPS + 1),
  localparam int unsigned ACC_W     = CODE_W + $clog2(N_REPEAT),
  localparam int unsigned ADDR_W    = $clog2(N_STEPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              locked,
  input  logic              phase_done,
  output logic              phase_en,
  output logic              fire,
  output logic              chain_ena,
  output logic              chain_clr,
  input  logic [N_TAPS-1:0] sout,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ACC_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned ShotW   = (N_REPEAT > 1) ? $clog2(N_REPEAT) : 1;
  localparam int unsigned TmoW    = $clog2(PH_TIMEOUT + 1);
  localparam int unsigned SettleW = $clog2(SettleCycles + 1);

  tdc_state_e state_q, state_d;

  logic [ADDR_W-1:0]  step_q;
  logic [ShotW-1:0]   shot_q;
  logic [ACC_W-1:0]   acc_q;
  logic [TmoW-1:0]    tmo_q;
  logic [SettleW-1:0] settle_q;
  logic [CODE_W-1:0]  count;

  logic tmo_hit, last_shot, last_step, settled;

  tdc_popcount #(
    .N_TAPS (N_TAPS),
    .CODE_W (CODE_W)
  ) u_popcount (
    .clk   (clk),
    .rst_n (rst_n),
    .sout  (sout),
    .count (count)
  );

  assign tmo_hit   = (tmo_q == TmoW'(PH_TIMEOUT - 1));
  assign last_shot = (shot_q == ShotW'(N_REPEAT - 1));
  assign last_step = (step_q == ADDR_W'(N_STEPS - 1));
  assign settled   = (settle_q == SettleW'(SettleCycles - 1));

  always_comb begin
    state_d = state_q;
    if (abort && (state_q != StIdle) && (state_q != StError)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StError: if (start && !abort) state_d = StLockWait;
        StLockWait:      if (locked) state_d = StPhReq;
        StPhReq: begin
          if (!phase_done)  state_d = StPhAck;
          else if (tmo_hit) state_d = StError;
        end
        StPhAck: begin
          if (phase_done)   state_d = StPhSettle;
          else if (tmo_hit) state_d = StError;
        end
        StPhSettle:      if (settled) state_d = StFire;
        StFire:          state_d = StCapture;
        StCapture:       state_d = StAccum;
        StAccum:         state_d = StClear;
        StClear:         state_d = last_shot ? StWrite : StFire;
        StWrite:         state_d = last_step ? StFinish : StPhReq;
        StFinish:        state_d = StIdle;
        default:         state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next state so they coincide with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      phase_en  <= 1'b0;
      fire      <= 1'b0;
      chain_ena <= 1'b0;
      chain_clr <= 1'b0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      step_q    <= '0;
      shot_q    <= '0;
      acc_q     <= '0;
      tmo_q     <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      phase_en  <= (state_d == StPhReq);
      fire      <= (state_d == StFire);
      chain_ena <= (state_d == StFire);
      chain_clr <= (state_d == StClear);
      wr_en     <= (state_d == StWrite);
      busy      <= !(state_d inside {StIdle, StFinish, StError});
      done      <= (state_d == StFinish);
      err       <= (state_d == StError);

      if (state_d != state_q) begin
        tmo_q <= '0;
      end else if (state_q inside {StPhReq, StPhAck}) begin
        tmo_q <= tmo_q + 1'b1;
      end

      if (state_d != state_q) begin
        settle_q <= '0;
      end else if (state_q == StPhSettle) begin
        settle_q <= settle_q + 1'b1;
      end

      // A fresh sweep starts from step 0 with nothing accumulated, whatever an abort left behind.
      if ((state_q inside {StIdle, StError}) && (state_d == StLockWait)) begin
        step_q <= '0;
        shot_q <= '0;
        acc_q  <= '0;
      end

      // count already holds the popcount of sout sampled during CAPTURE.
      if (state_q == StAccum) begin
        acc_q <= acc_q + ACC_W'(count);
      end

      if ((state_q == StClear) && (state_d == StFire)) begin
        shot_q <= shot_q + 1'b1;
      end

      if (state_d == StWrite) begin
        wr_addr <= step_q;
        wr_data <= acc_q;
      end

      if (state_q == StWrite) begin
        acc_q  <= '0;
        shot_q <= '0;
        if (state_d == StPhReq) begin
          step_q <= step_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdc_phase_sweep.sv
// Directed bench for tdc_phase_sweep: full sweeps, bubbled code, phase timeout, abort and reset.
module tb_tdc_phase_sweep;

  localparam int unsigned NTaps     = 16;
  localparam int unsigned NSteps    = 4;
  localparam int unsigned NRepeat   = 4;
  localparam int unsigned PhTimeout = 15;
  localparam int unsigned AccW      = 7;
  localparam int unsigned AddrW     = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start, abort, locked, phase_done;
  logic             phase_en, fire, chain_ena, chain_clr, wr_en, busy, done, err;
  logic [NTaps-1:0] sout;
  logic [AddrW-1:0] wr_addr;
  logic [AccW-1:0]  wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdc_phase_sweep #(
    .N_TAPS     (NTaps),
    .N_STEPS    (NSteps),
    .N_REPEAT   (NRepeat),
    .PH_TIMEOUT (PhTimeout)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .locked     (locked),
    .phase_done (phase_done),
    .phase_en   (phase_en),
    .fire       (fire),
    .chain_ena  (chain_ena),
    .chain_clr  (chain_clr),
    .sout       (sout),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // PLL model: on a request, phase_done drops for 3 cycles, then stays high for at least 5.
  logic pll_stuck = 1'b0;
  int   pll_cnt = 0;
  initial phase_done = 1'b1;
  always @(negedge clk) begin
    if (pll_stuck) begin
      phase_done = 1'b1;
      pll_cnt    = 0;
    end else if (pll_cnt > 0) begin
      pll_cnt = pll_cnt - 1;
      if (pll_cnt <= 5) phase_done = 1'b1;
    end else if (phase_en) begin
      pll_cnt    = 8;
      phase_done = 1'b0;
    end
  end

  // Write and done monitor.
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          done_total = 0;
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_addr_log.push_back(32'(wr_addr));
      wr_data_log.push_back(32'(wr_data));
    end
    if (done === 1'b1) done_total = done_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // sel: 0 done, 1 phase_en, 2 wr_en, 3 fire
  task automatic wait_high(input string tag, input int sel, input int budget);
    int   n;
    logic s;
    n = 0;
    s = 1'b0;
    while (n < budget) begin
      case (sel)
        0:       s = done;
        1:       s = phase_en;
        2:       s = wr_en;
        default: s = fire;
      endcase
      if (s === 1'b1) break;
      @(negedge clk);
      n++;
    end
    check(tag, 32'(s), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_sweep(input string tag, input int base, input logic [31:0] exp_data);
    check({tag, "_nwrites"}, 32'(wr_addr_log.size() - base), NSteps);
    for (int i = 0; i < int'(NSteps); i++) begin
      if (base + i < wr_addr_log.size()) begin
        check({tag, "_addr"}, wr_addr_log[base + i], 32'(i));
        check({tag, "_data"}, wr_data_log[base + i], exp_data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dbase;
    int n;
    start  = 1'b0;
    abort  = 1'b0;
    locked = 1'b1;
    sout   = 16'hFFFF;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 32'({phase_en, fire, chain_ena, chain_clr, wr_en, busy, done, err}), 0);
    check("reset_addr", 32'(wr_addr), 0);
    check("reset_data", 32'(wr_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweep, all taps set: 4 shots x 16 = 64 per step; a second start mid-sweep is ignored.
    base  = wr_addr_log.size();
    dbase = done_total;
    pulse_start();
    check("busy_after_start", 32'(busy), 1);
    repeat (10) @(negedge clk);
    check("busy_mid_sweep", 32'(busy), 1);
    pulse_start();
    wait_high("sweep1_done", 0, 400);
    repeat (2) @(negedge clk);
    check_sweep("sweep1", base, 32'd64);
    check("sweep1_done_once", 32'(done_total - dbase), 1);
    check("sweep1_idle_busy", 32'(busy), 0);
    check("sweep1_done_pulse", 32'(done), 0);

    // Bubbled code 0xD7 has 6 ones: 4 x 6 = 24.
    sout = 16'h00D7;
    base = wr_addr_log.size();
    pulse_start();
    wait_high("bubble_done", 0, 400);
    repeat (2) @(negedge clk);
    check_sweep("bubble", base, 32'd24);

    // phase_done stuck high: timeout after PhTimeout cycles in PH_REQ.
    sout = 16'hFFFF;
    pll_stuck = 1'b1;
    repeat (12) @(negedge clk);
    pulse_start();
    wait_high("tmo_req", 1, 10);
    n = 0;
    while (err !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tmo_err", 32'(err), 1);
    check("tmo_latency_max", 32'(n <= 16), 1);
    check("tmo_latency_min", 32'(n >= 14), 1);
    check("tmo_phase_en", 32'(phase_en), 0);
    check("tmo_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
    check("tmo_err_held", 32'(err), 1);
    pulse_start();
    check("tmo_err_cleared", 32'(err), 0);
    check("tmo_restart_busy", 32'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("tmo_abort_busy", 32'(busy), 0);
    pll_stuck = 1'b0;
    repeat (12) @(negedge clk);

    // Abort during the second step's first FIRE: only address 0 is written.
    base  = wr_addr_log.size();
    dbase = done_total;
    pulse_start();
    wait_high("abort_wr0", 2, 200);
    @(negedge clk);
    wait_high("abort_fire", 3, 100);
    abort = 1'b1;
    @(negedge clk);
    check("abort_busy1", 32'(busy), 0);
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy2", 32'(busy), 0);
    check("abort_phase_en", 32'(phase_en), 0);
    repeat (40) @(negedge clk);
    check("abort_nwrites", 32'(wr_addr_log.size() - base), 1);
    check("abort_no_done", 32'(done_total - dbase), 0);
    if (base < wr_addr_log.size()) check("abort_addr0", wr_addr_log[base], 0);

    // Reset pulsed mid-ACCUM: outputs clear immediately, next sweep restarts at address 0.
    base = wr_addr_log.size();
    pulse_start();
    wait_high("rst_fire", 3, 200);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ctrl", 32'({phase_en, fire, chain_ena, chain_clr, wr_en, busy, done, err}), 0);
    check("rst_data", 32'(wr_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_nwrites", 32'(wr_addr_log.size() - base), 0);
    base = wr_addr_log.size();
    pulse_start();
    wait_high("rst_sweep_done", 0, 400);
    repeat (2) @(negedge clk);
    check_sweep("rst_sweep", base, 32'd64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
